// File: rtl/fetch_pc_queue_pkg.sv
// Shared definitions for the fetch PC queue: default widths, instruction step, NOP encoding.
package fetch_pc_queue_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int ILEN_DEFAULT = 32;
    localparam int INSTR_BYTES  = 4;

    // Presented on deq_instr whenever the queue is empty so decode never sees garbage bits.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_queue_fifo.sv
// Generic synchronous FIFO with show-ahead head, flush and occupancy count.
// Used both as the decode-side output queue and as the in-flight PC tracker.
module fetch_pc_queue_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             wr_en;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push   = push && (!full || pop);
    assign do_pop    = pop && !empty;
    assign wr_en     = do_push && !flush;
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

    // Pointer and occupancy bookkeeping; flush empties the FIFO and discards a same-cycle push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Storage entry gi; data needs no reset since count gates its visibility.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fetch_pc_queue.sv
// Fetch PC owner: issues in-order imem requests under a credit limit, pairs responses
// with their PCs and queues {pc, instr} for decode. Redirect flushes and drops stale fetches.
module fetch_pc_queue
    import fetch_pc_queue_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEFAULT,
    parameter int               ILEN         = ILEN_DEFAULT,
    parameter int               DEPTH        = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [XLEN-1:0] deq_pc,
    output logic [ILEN-1:0] deq_instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]      pc_reg;
    logic [CW-1:0]        outstanding_reg;
    logic [CW-1:0]        outstanding_next;
    logic [CW-1:0]        drop_cnt_reg;
    logic [CW-1:0]        drop_cnt_next;

    logic [CW-1:0]        q_count;
    logic [CW-1:0]        trk_count;
    logic [XLEN+ILEN-1:0] q_head;
    logic [XLEN-1:0]      trk_head;
    logic [CW:0]          credit_sum;
    logic [XLEN-1:0]      redirect_aligned;

    logic                 req_fire;
    logic                 rsp_accept;
    logic                 rsp_drop;
    logic                 enq;
    logic                 deq_fire;
    logic                 unused_bits;

    // Every queued entry plus every in-flight fetch holds a slot, so a response always has room.
    assign credit_sum       = {1'b0, q_count} + {1'b0, outstanding_reg};
    assign imem_req_valid   = reset && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr    = pc_reg;
    assign req_fire         = imem_req_valid && imem_req_ready;

    // Stray responses with nothing outstanding (e.g. after reset) are ignored entirely.
    assign rsp_accept       = imem_rsp_valid && (outstanding_reg != '0);
    assign rsp_drop         = rsp_accept && (drop_cnt_reg != '0);
    assign enq              = rsp_accept && !rsp_drop && !redirect_valid;

    assign deq_valid        = (q_count != '0);
    assign deq_fire         = deq_valid && deq_ready;
    assign deq_pc           = q_head[XLEN+ILEN-1:ILEN];
    assign deq_instr        = deq_valid ? q_head[ILEN-1:0] : ILEN'(NOP_INSTR);

    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign pc               = pc_reg;
    assign unused_bits      = ^{redirect_pc[1:0], trk_count};

    // Next PC, in-flight count and drop count; redirect overrides all other updates.
    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
        drop_cnt_next    = drop_cnt_reg;
        if (redirect_valid) begin
            pc_next       = redirect_aligned;
            drop_cnt_next = outstanding_reg - CW'(rsp_accept);
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + XLEN'(INSTR_BYTES);
            end
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - 1'b1;
            end
        end
    end

    // Architectural fetch state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg          <= RESET_VECTOR;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    // PCs of requests whose responses will be kept; dropped fetches were flushed with redirect.
    fetch_pc_queue_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_trk (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc_reg),
        .pop       (enq),
        .head_data (trk_head),
        .count     (trk_count)
    );

    // Decode-facing queue of {pc, instr}.
    fetch_pc_queue_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data ({trk_head, imem_rsp_data}),
        .pop       (deq_fire),
        .head_data (q_head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: queue-based reference model, in-order memory model,
// directed sequences, a redirect alignment table and a randomized phase.
module tb_fetch_pc_queue;

    localparam int          XLEN  = 64;
    localparam int          ILEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RV    = 64'h0;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_valid;
    logic            deq_ready;
    logic [XLEN-1:0] deq_pc;
    logic [ILEN-1:0] deq_instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    fetch_pc_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_VECTOR(RV)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_instr(deq_instr),
        .pc(pc), .pc_next(pc_next)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; } mem_t;
    typedef struct { logic [63:0] pc; bit stale; } fl_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; } pair_t;
    typedef struct { logic [63:0] rpc; logic [63:0] exp_pc; logic [63:0] exp_next; } vec_t;

    mem_t        memq[$];
    fl_t         infl[$];
    pair_t       expq[$];
    logic [63:0] deq_log[$];
    logic [63:0] m_pc;
    bit          in_reset;
    int          lat_min = 1;
    int          lat_max = 1;
    int          cyc = 0;
    int          fire_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    bit          tbl_next_en = 0;
    logic [63:0] tbl_next;
    vec_t        vecs[5];

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample mid-cycle, compare, advance model.
    task automatic step();
        fl_t         f;
        logic [63:0] al;
        bit          exp_rv, rf, rsp;
        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_data(memq[0].addr) : 32'h0;
        #4;
        if (in_reset) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_deq_valid", deq_valid, 0);
            chk("rst_pc", pc, RV);
            if (rsp) void'(memq.pop_front());
        end else begin
            al     = {redirect_pc[63:2], 2'b00};
            exp_rv = !redirect_valid && ((expq.size() + infl.size()) < DEPTH);
            rf     = exp_rv && imem_req_ready;
            chk("req_valid", imem_req_valid, exp_rv);
            chk("pc", pc, m_pc);
            chk("req_addr", imem_req_addr, m_pc);
            chk("pc_next", pc_next, redirect_valid ? al : (rf ? m_pc + 64'd4 : m_pc));
            if (tbl_next_en) chk("tbl_pc_next", pc_next, tbl_next);
            if (expq.size() > 0) begin
                chk("deq_valid", deq_valid, 1);
                chk("deq_pc", deq_pc, expq[0].pc);
                chk("deq_instr", deq_instr, expq[0].instr);
                if (deq_ready) begin
                    $display("deq cyc=%0d pc=%h instr=%h", cyc, deq_pc, deq_instr);
                    deq_log.push_back(expq[0].pc);
                    void'(expq.pop_front());
                end
            end else begin
                chk("deq_valid_empty", deq_valid, 0);
            end
            if (rsp) begin
                void'(memq.pop_front());
                if (infl.size() > 0) begin
                    f = infl.pop_front();
                    if (!redirect_valid && !f.stale) expq.push_back('{f.pc, mem_data(f.pc)});
                end
            end
            if (redirect_valid) begin
                expq.delete();
                foreach (infl[i]) infl[i].stale = 1'b1;
                m_pc = al;
            end else if (rf) begin
                infl.push_back('{m_pc, 1'b0});
                memq.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min))});
                m_pc = m_pc + 64'd4;
                fire_cnt++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset assertion between edges; outputs must drop immediately.
    task automatic assert_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req_valid", imem_req_valid, 0);
        chk("async_rst_deq_valid", deq_valid, 0);
        chk("async_rst_pc", pc, RV);
        in_reset = 1'b1;
        expq.delete();
        infl.delete();
        m_pc = RV;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        deq_ready = 1'b1;
        for (int k = 0; k < 60 && (infl.size() > 0 || expq.size() > 0 || memq.size() > 0); k++) step();
        chk("drain_done", (infl.size() == 0 && expq.size() == 0), 1);
    endtask

    task automatic wait_deq(input string name, input logic [63:0] want);
        int d0;
        d0 = deq_log.size();
        for (int k = 0; k < 40 && deq_log.size() == d0; k++) step();
        chk({name, "_seen"}, deq_log.size() > d0, 1);
        if (deq_log.size() > d0) chk(name, deq_log[d0], want);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        vecs[0] = '{64'h0000_0000_0000_0103, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0104};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[2] = '{64'h0000_0000_0000_0002, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0004};
        vecs[3] = '{64'h8000_0000_0000_0007, 64'h8000_0000_0000_0004, 64'h8000_0000_0000_0008};
        vecs[4] = '{64'h0000_1234_5678_9ABD, 64'h0000_1234_5678_9ABC, 64'h0000_1234_5678_9AC0};

        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        in_reset       = 1'b1;
        m_pc           = RV;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        release_reset();

        // Sequential fetch, single-cycle memory, decode always ready.
        imem_req_ready = 1'b1;
        deq_ready = 1'b1;
        repeat (12) step();
        chk("t1_count", deq_log.size() >= 8, 1);
        for (int i = 0; i < 8 && i < deq_log.size(); i++) chk("t1_pc", deq_log[i], 64'(4 * i));
        d0 = deq_log.size();
        repeat (8) step();
        chk("t1_rate", deq_log.size() - d0, 8);

        // Backpressure from reset: exactly DEPTH requests, then stall; drain in order.
        assert_reset();
        step();
        for (int k = 0; k < 10 && memq.size() > 0; k++) step();
        release_reset();
        deq_ready = 1'b0;
        fire_cnt = 0;
        repeat (10) step();
        chk("t2_fires", fire_cnt, DEPTH);
        chk("t2_req_valid", imem_req_valid, 0);
        chk("t2_pc", pc, 64'd16);
        d0 = deq_log.size();
        deq_ready = 1'b1;
        repeat (10) step();
        for (int i = 0; i < 6 && d0 + i < deq_log.size(); i++) chk("t2_drain_pc", deq_log[d0 + i], 64'(4 * i));

        // Redirect with two fetches in flight.
        lat_min = 4;
        lat_max = 4;
        drain();
        imem_req_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        step();
        redirect_valid = 1'b0;
        chk("t3_qempty", deq_valid, 0);
        chk("t3_pc", pc, 64'h100);
        wait_deq("t3_first_pc", 64'h100);

        // Redirect alignment and wrap table.
        lat_min = 1;
        lat_max = 1;
        drain();
        foreach (vecs[i]) begin
            imem_req_ready = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc = vecs[i].rpc;
            step();
            redirect_valid = 1'b0;
            chk("t4_pc", pc, vecs[i].exp_pc);
            imem_req_ready = 1'b1;
            tbl_next = vecs[i].exp_next;
            tbl_next_en = 1'b1;
            step();
            tbl_next_en = 1'b0;
            chk("t4_pc_after_fetch", pc, vecs[i].exp_next);
        end

        // Redirect coinciding with a response and a dequeue.
        lat_min = 2;
        lat_max = 2;
        drain();
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 50 && !((memq.size() > 0) && (memq[0].due <= cyc) && (deq_valid === 1'b1)); k++) step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        step();
        redirect_valid = 1'b0;
        chk("t5_qempty", deq_valid, 0);
        wait_deq("t5_first_pc", 64'h200);

        // Reset mid-burst with responses pending; stray responses after release.
        lat_min = 5;
        lat_max = 5;
        imem_req_ready = 1'b1;
        repeat (6) step();
        assert_reset();
        step();
        release_reset();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 30 && memq.size() > 0; k++) step();
        chk("t6_no_stray_deq", deq_valid, 0);
        chk("t6_pc", pc, RV);
        imem_req_ready = 1'b1;
        wait_deq("t6_first_pc", RV);

        // Randomized traffic.
        lat_min = 1;
        lat_max = 3;
        for (int n = 0; n < 1500; n++) begin
            imem_req_ready = ($urandom_range(9, 0) < 7);
            deq_ready      = ($urandom_range(9, 0) < 6);
            redirect_valid = ($urandom_range(19, 0) == 0);
            if ($urandom_range(3, 0) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            else redirect_pc = {$urandom, $urandom};
            step();
        end
        redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
